// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, 5..8 data bits LSB-first, optional parity, 1-2 stop bits.
// Latency: start bit is on tx right after the accept edge; each bit lasts CLK_FREQ/UART_BPS cycles.
// Backpressure: requests while busy are dropped; busy/tx_done pace the next character.
module uart_tx_cfg #(
    parameter int UART_BPS  = 9600,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int          BIT_PERIOD = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BAUD_LAST  = 16'(BIT_PERIOD - 1);
    localparam logic [7:0]  DATA_MASK  = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]  LAST_DATA  = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP  = 3'(STOP_BITS - 1);
    localparam bit          HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  data_q;
    logic        parity_q;

    logic [7:0]  data_in;
    logic        parity_in;
    logic        bit_end;

    // Unused upper bits are masked so they can never reach the line or the parity.
    assign data_in   = pi_data & DATA_MASK;
    assign parity_in = (PARITY == 1) ? ~(^data_in) : (^data_in);
    assign bit_end   = (baud_cnt == BAUD_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != S_IDLE) begin
                baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (pi_flag) begin
                        data_q   <= data_in;
                        parity_q <= parity_in;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        tx      <= data_q[0];
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                tx    <= parity_q;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            tx      <= data_q[bit_cnt + 3'd1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8N1, 7E2 and 8O1 instances at 10 clocks per bit.
module tb_uart_tx_cfg;

    localparam int M = 10;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [2:0]      flag;
    logic [2:0][7:0] data;
    logic [2:0]      tx;
    logic [2:0]      busy;
    logic [2:0]      done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx_cfg #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(data[0]), .pi_flag(flag[0]),
        .tx(tx[0]), .busy(busy[0]), .tx_done(done[0])
    );

    uart_tx_cfg #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(data[1]), .pi_flag(flag[1]),
        .tx(tx[1]), .busy(busy[1]), .tx_done(done[1])
    );

    uart_tx_cfg #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(data[2]), .pi_flag(flag[2]),
        .tx(tx[2]), .busy(busy[2]), .tx_done(done[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int idx, input logic [7:0] d);
        @(negedge sys_clk);
        data[idx] = d;
        flag[idx] = 1'b1;
    endtask

    // Walks cycles 0..F*M after the accept edge; exp bit k is frame bit k (bit 0 = start).
    task automatic run_frame(input int idx, input int nbits, input logic [11:0] exp, input bit hold,
                             input int inj_cyc, input logic [7:0] inj_data, input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        for (int c = 0; c <= nbits * M; c++) begin
            @(negedge sys_clk);
            if (c == 0) begin
                check({tag, "_start_tx"}, 32'(tx[idx]), 32'd0);
                check({tag, "_start_busy"}, 32'(busy[idx]), 32'd1);
            end
            if (c < nbits * M && (c % M) == M / 2)
                check($sformatf("%s_bit%0d", tag, c / M), 32'(tx[idx]), 32'(exp[c / M]));
            if (c < nbits * M && busy[idx]) busy_cnt++;
            if (done[idx]) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 0 && !hold) flag[idx] = 1'b0;
            if (c == inj_cyc) begin
                flag[idx] = 1'b1;
                data[idx] = inj_data;
            end else if (!hold && inj_cyc >= 0 && c == inj_cyc + 1) begin
                flag[idx] = 1'b0;
            end
        end
        check({tag, "_end_busy"}, 32'(busy[idx]), 32'd0);
        check({tag, "_end_tx"}, 32'(tx[idx]), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(nbits * M));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(nbits * M));
    endtask

    initial begin
        int extra;
        flag      = '0;
        data      = '0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_tx%0d", i), 32'(tx[i]), 32'd1);
            check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        send(0, 8'hA5);
        run_frame(0, 10, 12'h34A, 1'b0, -1, 8'h00, "8n1_a5");

        // 7E2 0xD3: bit 7 dropped, data 1,1,0,0,1,0,1, parity 0, two stops
        send(1, 8'hD3);
        run_frame(1, 11, 12'h6A6, 1'b0, -1, 8'h00, "7e2_d3");

        // 8O1: 0x00 -> parity 1, 0x01 -> parity 0
        send(2, 8'h00);
        run_frame(2, 11, 12'h600, 1'b0, -1, 8'h00, "8o1_00");
        send(2, 8'h01);
        run_frame(2, 11, 12'h402, 1'b0, -1, 8'h00, "8o1_01");

        // Request for 0xFF in the middle of a 0x0F frame must be dropped
        send(0, 8'h0F);
        run_frame(0, 10, 12'h21E, 1'b0, 50, 8'hFF, "busy_req");
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            if (busy[0] || done[0] || !tx[0]) extra++;
        end
        check("busy_req_no_queue", 32'(extra), 32'd0);

        // Back-to-back with pi_flag held: 0x55 then 0x33, second start 101 cycles later
        send(0, 8'h55);
        run_frame(0, 10, 12'h2AA, 1'b1, 0, 8'h33, "b2b_1");
        run_frame(0, 10, 12'h266, 1'b1, -1, 8'h00, "b2b_2");
        flag[0] = 1'b0;

        // Asynchronous reset at cycle 35 of an 0xA5 frame
        send(0, 8'hA5);
        @(negedge sys_clk);
        flag[0] = 1'b0;
        repeat (35) @(negedge sys_clk);
        check("mid_busy_before_rst", 32'(busy[0]), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx[0]), 32'd1);
        check("async_rst_busy", 32'(busy[0]), 32'd0);
        check("async_rst_done", 32'(done[0]), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            if (busy[0] || done[0] || !tx[0]) extra++;
        end
        check("post_rst_idle", 32'(extra), 32'd0);
        send(0, 8'hA5);
        run_frame(0, 10, 12'h34A, 1'b0, -1, 8'h00, "post_rst_a5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
